// File: rtl/rst_seq_ctrl_pkg.sv
// Shared types and default constants for the reset sequencer, used by the RTL and the bench.
package rst_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_RELEASE = 2'd2,
        ST_DONE    = 2'd3
    } seq_state_t;

    localparam int unsigned DEF_NUM_DOMAINS    = 4;
    localparam int unsigned DEF_NUM_REQ        = 2;
    localparam int unsigned DEF_ASSERT_CYCLES  = 32;
    localparam int unsigned DEF_STAGGER_CYCLES = 8;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rst_seq_timer.sv
// Clearable up-counter timing both the ASSERT hold and the per-domain stagger.
module rst_seq_timer #(
    parameter int unsigned CW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [CW-1:0] term,
    output logic          tc
);

    logic [CW-1:0] cnt;

    assign tc = en && (cnt == term);

    // Self-clears at terminal count and whenever idle, so it never wraps.
    always_ff @(posedge clk) begin
        if (rst || !en || tc) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: holds all domains in reset, releases them in index order, and
// arbitrates soft-reset requesters with one ack per serviced sequence.
module rst_seq_ctrl
    import rst_seq_ctrl_pkg::*;
#(
    parameter int unsigned NUM_DOMAINS    = DEF_NUM_DOMAINS,
    parameter int unsigned NUM_REQ        = DEF_NUM_REQ,
    parameter int unsigned ASSERT_CYCLES  = DEF_ASSERT_CYCLES,
    parameter int unsigned STAGGER_CYCLES = DEF_STAGGER_CYCLES
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic [NUM_REQ-1:0]     req_i,
    output logic [NUM_REQ-1:0]     ack_o,
    output logic [NUM_DOMAINS-1:0] rst_o,
    output logic                   busy_o,
    output logic                   done_o
);

    localparam int unsigned CW = $clog2(max_u(ASSERT_CYCLES, STAGGER_CYCLES) + 1);
    localparam int unsigned IW = $clog2(NUM_DOMAINS) + 1;
    localparam logic [CW-1:0] ASRT_TERM = CW'(ASSERT_CYCLES - 1);
    localparam logic [CW-1:0] STAG_TERM = CW'(STAGGER_CYCLES - 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_DOMAINS - 1);

    seq_state_t       state, state_n;
    logic [IW-1:0]    idx, idx_n;
    logic [NUM_REQ-1:0] pend, pend_n;
    logic [NUM_REQ-1:0] serv, serv_n;
    logic             tmr_en;
    logic [CW-1:0]    tmr_term;
    logic             tc;

    assign tmr_en   = (state == ST_ASSERT) || (state == ST_RELEASE);
    assign tmr_term = (state == ST_RELEASE) ? STAG_TERM : ASRT_TERM;

    rst_seq_timer #(
        .CW (CW)
    ) u_timer (
        .clk  (wb_clk_i),
        .rst  (wb_rst_i),
        .en   (tmr_en),
        .term (tmr_term),
        .tc   (tc)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= ST_ASSERT;
            idx   <= '0;
            pend  <= '0;
            serv  <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            pend  <= pend_n;
            serv  <= serv_n;
        end
    end

    // DONE is the cycle the last domain drops, so RELEASE hands over one index early.
    always_comb begin
        state_n = state;
        idx_n   = idx;
        pend_n  = pend | req_i;
        serv_n  = serv;
        case (state)
            ST_IDLE: begin
                if (pend_n != '0) begin
                    state_n = ST_ASSERT;
                    serv_n  = pend_n;
                    pend_n  = '0;
                end
            end
            ST_ASSERT: begin
                if (tc) begin
                    idx_n   = '0;
                    state_n = (NUM_DOMAINS == 1) ? ST_DONE : ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (tc) begin
                    idx_n = idx + IW'(1);
                    if (idx_n == LAST_IDX) begin
                        state_n = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (pend_n != '0) begin
                    state_n = ST_ASSERT;
                    serv_n  = pend_n;
                    pend_n  = '0;
                end else begin
                    state_n = ST_IDLE;
                    serv_n  = '0;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        rst_o  = '0;
        busy_o = 1'b1;
        done_o = 1'b0;
        ack_o  = '0;
        case (state)
            ST_IDLE: begin
                busy_o = 1'b0;
            end
            ST_ASSERT: begin
                rst_o = '1;
            end
            ST_RELEASE: begin
                for (int unsigned i = 0; i < NUM_DOMAINS; i++) begin
                    rst_o[i] = (IW'(i) > idx);
                end
            end
            ST_DONE: begin
                done_o = 1'b1;
                ack_o  = serv;
            end
            default: busy_o = 1'b0;
        endcase
    end

endmodule
